div_result_bcd: RTL
===================

Name: div_result_bcd

Overview:
Downstream stage of the signed 8-bit divider. Detects the divider's data_ok rising edge and captures the signed quotient and remainder. Converts both to sign + 3-digit BCD with a sequential double-dabble, and presents the result to the display/readout logic with a completion flag.

Parameters:
W, 8, input operand width (two's complement)
DIGITS, 3, BCD digits per value; must satisfy 10^DIGITS > 2^(W-1)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
data_ok  input  1  divider completion flag (level; held high once done)
Q_reg  input  W  divider quotient, two's complement
R_reg  input  W  divider remainder, two's complement
busy  output  1  conversion in progress
bcd_ok  output  1  BCD outputs valid
q_neg  output  1  quotient sign (1 = negative)
q_bcd  output  4*DIGITS  quotient magnitude, packed BCD, MS digit in top nibble
r_neg  output  1  remainder sign
r_bcd  output  4*DIGITS  remainder magnitude, packed BCD

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE.
  - busy=0, bcd_ok=0, q_neg=0, r_neg=0, q_bcd=0, r_bcd=0.
  - Shift counter=0.
  - data_ok history register=0. If data_ok is still high when rst releases, this counts as a rising edge.
  - Reset has priority over every other event, including mid-CONV. A partial conversion is discarded and its outputs are never updated.
- Edge detect: start = data_ok & ~data_ok_d. data_ok_d is registered every cycle in every state.
- States: IDLE, CONV, DONE.
- IDLE:
  - On start, capture sign bits and magnitudes.
  - Magnitude = operand if MSB=0, else ~operand+1, computed in W+1 bits so that 8'h80 yields 128.
  - Clear both BCD accumulators, set counter=0, set busy=1, go to CONV.
- CONV (one bit per cycle, both values in parallel):
  - Add 3 to every accumulator digit >=5.
  - Shift {accumulator, magnitude} left by 1.
  - Counter increments.
  - On the W-th shift: load q_bcd/r_bcd/q_neg/r_neg from the final accumulators, busy=0, bcd_ok=1, go to DONE.
  - A start during CONV is ignored and is not queued.
- DONE:
  - Outputs held stable. bcd_ok stays 1.
  - On start: bcd_ok=0, capture as in IDLE, go to CONV. Output registers keep their old values until the new conversion completes.
- Latency: capture at edge N; bcd_ok and outputs valid after edge N+W (8 cycles for W=8). busy is high after edges N through N+W-1.
- Outputs only change on the final CONV cycle or on reset. They never show intermediate values.
- Zero input: magnitude 0 gives BCD 0 and sign 0.
- A negative operand always gives neg=1 with a nonzero magnitude.

Optional Feature:
- Macro: DIV_BCD_ZERO_BLANK_EN.
- When defined: leading zero digits of q_bcd/r_bcd are replaced by 4'hF (blank code) when the outputs are loaded. The least-significant digit is never blanked, so value 0 gives 12'hFF0.
- When undefined: plain zero-padded BCD; 4'hF never appears.
- Blanking does not change timing, busy or bcd_ok.

Test Plan:
- Q_reg=8'hFD, R_reg=8'hFE, data_ok rises at edge N -> at edge N+8: bcd_ok=1, q_neg=1, q_bcd=12'h003, r_neg=1, r_bcd=12'h002. busy is 1 during edges N..N+7.
- Q_reg=8'h7F, R_reg=8'h00 -> q_neg=0, q_bcd=12'h127, r_neg=0, r_bcd=12'h000. Edge case 8'h80 -> q_neg=1, q_bcd=12'h128.
- rst pulsed at edge N+4 of a conversion with data_ok held low -> all outputs 0, busy=0, bcd_ok=0, state IDLE. No output ever shows partial data.
- data_ok held high through rst release with Q=8'h0A -> capture on the first post-reset edge; 8 cycles later q_bcd=12'h010.
- Second data_ok rise (low for one cycle, then high) at edge N+3 during CONV -> ignored; the first result completes normally. A rise while in DONE restarts: bcd_ok drops for 8 cycles, then new values appear.
- With DIV_BCD_ZERO_BLANK_EN defined: Q=8'h05, R=8'h00 -> q_bcd=12'hFF5, r_bcd=12'hFF0. Q=8'h9C (-100) -> q_neg=1, q_bcd=12'h100.

Source files
------------

// File: rtl/div_result_bcd.sv
// div_result_bcd: captures signed quotient/remainder on data_ok rise and converts both to sign + packed BCD via sequential double-dabble.
// Optional: define DIV_BCD_ZERO_BLANK_EN to replace leading zero digits with 4'hF on output load.
module div_result_bcd #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_ok,
    input  logic [W-1:0]        Q_reg,
    input  logic [W-1:0]        R_reg,
    output logic                busy,
    output logic                bcd_ok,
    output logic                q_neg,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic                r_neg,
    output logic [4*DIGITS-1:0] r_bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        r_state;
    logic          r_data_ok_d;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_q_mag, r_r_mag;
    logic [BW-1:0] r_q_acc, r_r_acc;
    logic          r_q_sign, r_r_sign;

    logic          w_start, w_last;
    logic [BW-1:0] w_q_adj, w_r_adj, w_q_next, w_r_next;

    // Magnitude of a two's complement value; the most negative value wraps to itself, which read unsigned is the correct magnitude.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    // Double-dabble correction: add 3 to every digit that is 5 or more before the shift.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
        logic [BW-1:0] o;
        o = '0;
        for (int i = 0; i < DIGITS; i++)
            o[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
        return o;
    endfunction

    // Output formatting: leading zero digits blanked when enabled; the least significant digit always shows.
    function automatic logic [BW-1:0] fmt(input logic [BW-1:0] a);
`ifdef DIV_BCD_ZERO_BLANK_EN
        logic          lead;
        logic [BW-1:0] o;
        o    = a;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && a[4*i +: 4] == 4'd0)
                o[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
        return o;
`else
        return a;
`endif
    endfunction

    // Next accumulator values for one conversion step, plus edge detect and final-step flag.
    always_comb begin
        w_start  = data_ok & ~r_data_ok_d;
        w_last   = (r_cnt == CW'(W - 1));
        w_q_adj  = add3(r_q_acc);
        w_r_adj  = add3(r_r_acc);
        w_q_next = {w_q_adj[BW-2:0], r_q_mag[W-1]};
        w_r_next = {w_r_adj[BW-2:0], r_r_mag[W-1]};
    end

    // Control FSM with registered outputs; outputs load only on the final conversion step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data_ok_d <= 1'b0;
            r_cnt       <= '0;
            r_q_mag     <= '0;
            r_r_mag     <= '0;
            r_q_acc     <= '0;
            r_r_acc     <= '0;
            r_q_sign    <= 1'b0;
            r_r_sign    <= 1'b0;
            busy        <= 1'b0;
            bcd_ok      <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            q_bcd       <= '0;
            r_bcd       <= '0;
        end else begin
            r_data_ok_d <= data_ok;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_q_sign <= Q_reg[W-1];
                        r_r_sign <= R_reg[W-1];
                        r_q_mag  <= mag(Q_reg);
                        r_r_mag  <= mag(R_reg);
                        r_q_acc  <= '0;
                        r_r_acc  <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        bcd_ok   <= 1'b0;
                        r_state  <= CONV;
                    end
                end
                CONV: begin
                    r_q_acc <= w_q_next;
                    r_r_acc <= w_r_next;
                    r_q_mag <= r_q_mag << 1;
                    r_r_mag <= r_r_mag << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        q_bcd   <= fmt(w_q_next);
                        r_bcd   <= fmt(w_r_next);
                        q_neg   <= r_q_sign;
                        r_neg   <= r_r_sign;
                        busy    <= 1'b0;
                        bcd_ok  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
